// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the 1-to-8 TDM demultiplexer: slot geometry, FSM states
// and the even-parity helper used when TDM_DEMUX_PARITY_EN is defined.
package tdm_demux_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int SLOT_W    = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Even parity: the check bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [NUM_SLOTS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Free-running slot counter: increments on en_i, loads 1 on load1_i, and flags
// when it sits on the last slot of the frame.
module tdm_slot_counter
  import tdm_demux_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              load1_i,
  output logic [SLOT_W-1:0] cnt_o,
  output logic              wrap_o
);

  logic [SLOT_W-1:0] cnt_q;
  logic [SLOT_W-1:0] cnt_d;

  // Next count: a load (frame restart) takes priority over a plain increment.
  always_comb begin
    cnt_d = cnt_q;
    if (load1_i) begin
      cnt_d = SLOT_W'(1);
    end else if (en_i) begin
      cnt_d = cnt_q + SLOT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = (cnt_q == SLOT_W'(NUM_SLOTS - 1));

endmodule

// File: rtl/tdm_demux.sv
// 1-to-8 time-division demultiplexer top: FSM, shadow register, parallel output
// register and sticky sync_err. Optional trailing parity strobe: TDM_DEMUX_PARITY_EN.
module tdm_demux
  import tdm_demux_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync,
  input  logic in,
  output logic s2,
  output logic s1,
  output logic s0,
  output logic d0,
  output logic d1,
  output logic d2,
  output logic d3,
  output logic d4,
  output logic d5,
  output logic d6,
  output logic d7,
  output logic frame_valid,
`ifdef TDM_DEMUX_PARITY_EN
  output logic parity_err,
`endif
  output logic sync_err
);

  state_t                 state_q, state_d;
  logic [NUM_SLOTS-1:0]   shadow_q, shadow_d;
  logic [NUM_SLOTS-1:0]   dout_q, dout_d;
  logic                   fv_q, fv_d;
  logic                   serr_q, serr_d;
  logic                   cnt_en_s;
  logic                   cnt_load_s;
  logic                   last_slot_s;
  logic [SLOT_W-1:0]      slot_s;
`ifdef TDM_DEMUX_PARITY_EN
  logic                   perr_q, perr_d;
`endif

  tdm_slot_counter u_slot_counter (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .en_i    (cnt_en_s),
    .load1_i (cnt_load_s),
    .cnt_o   (slot_s),
    .wrap_o  (last_slot_s)
  );

  // Frame sequencing: capture strobes, publish on the last strobe, flag truncation.
  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    dout_d     = dout_q;
    fv_d       = 1'b0;
    serr_d     = serr_q;
    cnt_en_s   = 1'b0;
    cnt_load_s = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    perr_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (en && sync) begin
          shadow_d[0] = in;
          cnt_load_s  = 1'b1;
          state_d     = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (en && sync && (slot_s != '0)) begin
          serr_d      = 1'b1;
          shadow_d[0] = in;
          cnt_load_s  = 1'b1;
        end else if (en) begin
          shadow_d[slot_s] = in;
          cnt_en_s         = 1'b1;
          if (last_slot_s) begin
`ifdef TDM_DEMUX_PARITY_EN
            // Hold the counter on 7 so s2..s0 read 7 while the parity bit is awaited.
            cnt_en_s = 1'b0;
            state_d  = PARITY;
`else
            dout_d = {in, shadow_q[NUM_SLOTS-2:0]};
            fv_d   = 1'b1;
`endif
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
`ifdef TDM_DEMUX_PARITY_EN
      PARITY: begin
        if (en && sync) begin
          serr_d      = 1'b1;
          shadow_d[0] = in;
          cnt_load_s  = 1'b1;
          state_d     = RUN;
        end else if (en) begin
          dout_d   = shadow_q;
          fv_d     = 1'b1;
          perr_d   = (even_parity(shadow_q) != in);
          cnt_en_s = 1'b1;
          state_d  = RUN;
        end else begin
          state_d = PARITY;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, shadow and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      dout_q   <= '0;
      fv_q     <= 1'b0;
      serr_q   <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      perr_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      fv_q     <= fv_d;
      serr_q   <= serr_d;
`ifdef TDM_DEMUX_PARITY_EN
      perr_q   <= perr_d;
`endif
    end
  end

  assign {s2, s1, s0} = slot_s;
  assign {d7, d6, d5, d4, d3, d2, d1, d0} = dout_q;
  assign frame_valid = fv_q;
  assign sync_err    = serr_q;
`ifdef TDM_DEMUX_PARITY_EN
  assign parity_err  = perr_q;
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Randomized self-checking bench for tdm_demux; the reference model collects
// strobed bits into a queue and publishes a frame when the queue is full.
module tb_tdm_demux;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;
  logic sync  = 1'b0;
  logic din   = 1'b0;
  logic s2, s1, s0;
  logic d0, d1, d2, d3, d4, d5, d6, d7;
  logic frame_valid, sync_err;
`ifdef TDM_DEMUX_PARITY_EN
  logic parity_err;
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  int n_cmp = 0;
  int n_err = 0;

  bit         m_run;
  bit         m_q[$];
  logic [7:0] m_d;
  logic       m_fv, m_serr, m_perr;

  tdm_demux dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sync        (sync),
    .in          (din),
    .s2          (s2),
    .s1          (s1),
    .s0          (s0),
    .d0          (d0),
    .d1          (d1),
    .d2          (d2),
    .d3          (d3),
    .d4          (d4),
    .d5          (d5),
    .d6          (d6),
    .d7          (d7),
    .frame_valid (frame_valid),
`ifdef TDM_DEMUX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_slot();
    if (!m_run) return 0;
    return (m_q.size() > 7) ? 7 : m_q.size();
  endfunction

  task automatic model_reset();
    m_run = 1'b0;
    m_q.delete();
    m_d    = 8'h00;
    m_fv   = 1'b0;
    m_serr = 1'b0;
    m_perr = 1'b0;
  endtask

  // A frame is whatever bits were collected since the last sync; full queue => publish.
  task automatic model_step(input logic e, input logic s, input logic b);
    m_fv   = 1'b0;
    m_perr = 1'b0;
    if (e) begin
      if (!m_run) begin
        if (s) begin
          m_run = 1'b1;
          m_q.delete();
          m_q.push_back(b);
        end
      end else if (s) begin
        if (m_q.size() != 0) m_serr = 1'b1;
        m_q.delete();
        m_q.push_back(b);
      end else begin
        m_q.push_back(b);
        if (m_q.size() == FLEN) begin
          for (int i = 0; i < 8; i++) m_d[i] = m_q[i];
          m_fv = 1'b1;
          if (FLEN == 9) m_perr = ((^m_d) != m_q[FLEN-1]);
          m_q.delete();
        end
      end
    end
  endtask

  task automatic compare_all();
    check_eq("slot", 32'({s2, s1, s0}), 32'(exp_slot()));
    check_eq("dout", 32'({d7, d6, d5, d4, d3, d2, d1, d0}), 32'(m_d));
    check_eq("frame_valid", 32'(frame_valid), 32'(m_fv));
    check_eq("sync_err", 32'(sync_err), 32'(m_serr));
`ifdef TDM_DEMUX_PARITY_EN
    check_eq("parity_err", 32'(parity_err), 32'(m_perr));
`endif
  endtask

  task automatic strobe(input logic e, input logic s, input logic b);
    en   = e;
    sync = s;
    din  = b;
    @(posedge clk);
    model_step(e, s, b);
    #1;
    compare_all();
  endtask

  // Asserted between edges so the clear must be asynchronous.
  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    compare_all();
  endtask

  task automatic send_frame(input logic [7:0] b, input bit with_sync, input bit gap, input bit flip);
    for (int i = 0; i < 8; i++) begin
      if (gap && i != 0) strobe(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      strobe(1'b1, with_sync && (i == 0), b[i]);
    end
`ifdef TDM_DEMUX_PARITY_EN
    if (gap) strobe(1'b0, 1'b0, 1'b0);
    strobe(1'b1, 1'b0, (^b) ^ flip);
`else
    if (flip) check_eq("flip_unused", 32'(flip), 32'(0));
`endif
  endtask

  initial begin
    model_reset();
    #3;
    compare_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Strobes before any sync are ignored.
    for (int i = 0; i < 4; i++) strobe(1'b1, 1'b0, 1'b1);
    check_eq("idle_slot", 32'({s2, s1, s0}), 32'(0));

    // Basic frame 1,0,1,1,0,0,1,0 on slots 0..7.
    send_frame(8'b0100_1101, 1'b1, 1'b0, 1'b0);
    check_eq("tp1_dout", 32'({d7, d6, d5, d4, d3, d2, d1, d0}), 32'h4D);
    check_eq("tp1_fv", 32'(frame_valid), 32'(1));
    strobe(1'b0, 1'b0, 1'b0);
    check_eq("tp1_fv_once", 32'(frame_valid), 32'(0));

    // Back-to-back frames with en toggling.
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
    check_eq("a5_dout", 32'({d7, d6, d5, d4, d3, d2, d1, d0}), 32'hA5);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b0);
    check_eq("3c_dout", 32'({d7, d6, d5, d4, d3, d2, d1, d0}), 32'h3C);
    check_eq("b2b_serr", 32'(sync_err), 32'(0));

    // Sync at slot 5 truncates the frame.
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b0, 1'b1);
    send_frame(8'h96, 1'b1, 1'b0, 1'b0);
    check_eq("trunc_dout", 32'({d7, d6, d5, d4, d3, d2, d1, d0}), 32'h96);
    check_eq("trunc_serr", 32'(sync_err), 32'(1));

    // Reset at slot 4, then a clean frame.
    for (int i = 0; i < 4; i++) strobe(1'b1, i == 0, 1'b1);
    check_eq("pre_rst_slot", 32'({s2, s1, s0}), 32'(4));
    do_reset();
    send_frame(8'h5E, 1'b1, 1'b0, 1'b0);
    check_eq("post_rst_dout", 32'({d7, d6, d5, d4, d3, d2, d1, d0}), 32'h5E);

`ifdef TDM_DEMUX_PARITY_EN
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    check_eq("par_ok_fv", 32'(frame_valid), 32'(1));
    check_eq("par_ok_perr", 32'(parity_err), 32'(0));
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1);
    check_eq("par_bad_fv", 32'(frame_valid), 32'(1));
    check_eq("par_bad_perr", 32'(parity_err), 32'(1));
`endif

    // Randomized traffic, biased toward syncs at frame boundaries.
    for (int n = 0; n < 800; n++) begin
      logic e, s, b;
      e = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 24) == 0) || ((exp_slot() == 0) && ($urandom_range(0, 1) == 1));
      b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 249) == 0) do_reset();
      else strobe(e, s, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Sequential 1-to-8 time-division demultiplexer: receives one serial data bit per strobe, steers each bit into the slot given by a free-running 3-bit slot counter, and presents all eight slots in parallel once per frame. It is the receiving end of the 8:1 select-driven mux path, so the bit order on `in` matches the mux's d0..d7 select order. The select lines s2..s0 become outputs, driven by the internal counter.

## Interface
- Parameters: none. Slot count is fixed at 8 by `tdm_demux_pkg::NUM_SLOTS`.
- `clk` input, 1 bit: the single clock. All state changes on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `en` input, 1 bit: sample strobe. `in` is taken only on cycles where `en`=1.
- `sync` input, 1 bit: frame start marker. Qualified by `en`.
- `in` input, 1 bit: serial data.
- `s2`, `s1`, `s0` output, 1 bit each: current slot number. s2 is the MSB.
- `d0` through `d7` output, 1 bit each: parallel frame, held until the next complete frame.
- `frame_valid` output, 1 bit: one-cycle pulse when d0..d7 update.
- `sync_err` output, 1 bit: sticky flag, set when a frame is truncated.

## Operation
- FSM states: IDLE (reset state) and RUN. The PARITY state exists only with the macro; see Configuration.
- IDLE:
  - `en`=1 and `sync`=0: the strobe is ignored.
  - `en`=1 and `sync`=1: store `in` into shadow bit 0, set slot to 1, go to RUN.
- RUN, each `en`=1 cycle:
  - Store `in` into shadow bit [slot].
  - Increment slot modulo 8.
  - When slot was 7: copy shadow bits 0..7 into d0..d7, pulse `frame_valid`, set slot to 0, stay in RUN.
- `sync`=1 with `en`=1 in RUN:
  - Slot 0: this is a normal frame start.
  - Any other slot: the partial frame is discarded. d0..d7 are unchanged and there is no `frame_valid` pulse. `sync_err` is set. The current `in` goes to shadow bit 0 and slot becomes 1.
- `sync` with `en`=0 is ignored.
- `en`=0: slot, shadow bits and outputs all hold.
- `sync_err` clears only on reset.
- s2..s0 always equal the slot that the next strobe will fill. In IDLE they read 0.

## Timing
- Reset value of every output is 0: s2..s0, d0..d7, `frame_valid`, `sync_err`. FSM resets to IDLE and the shadow register to 0.
- Asserting `rst_n` mid-frame discards the frame. Outputs go to 0 immediately, without waiting for a clock edge.
- Latency: d0..d7 and `frame_valid` update on the clock edge that samples the slot-7 strobe. They are visible in the following cycle.
- `frame_valid` is high for exactly one cycle per completed frame. With `en` held at 1, frames complete every 8 cycles.
- Back-to-back frames need no gap cycle.
- A sync at slot 0 immediately after a frame completes is legal and does not set `sync_err`.

## Configuration
- Macro: `TDM_DEMUX_PARITY_EN`.
- Defined:
  - After slot 7, the FSM enters PARITY, and the next strobe samples an even-parity bit covering slots 0..7.
  - d0..d7 and `frame_valid` update only on that parity strobe, one strobe later than without the macro.
  - An extra output `parity_err` (1 bit, reset 0) pulses together with `frame_valid` when the parity mismatches. The data is still delivered.
  - A sync during PARITY is treated as truncation.
  - While in PARITY, s2..s0 read 7.
- Undefined: the PARITY state, the parity logic and the `parity_err` port are all absent. The frame is 8 strobes.

## Structure
- Shared package `tdm_demux_pkg`:
  - `NUM_SLOTS` = 8 and `SLOT_W` = 3.
  - `state_t` enum with IDLE, RUN and PARITY.
- One sub-module, `tdm_slot_counter`: a 3-bit counter with `en`, synchronous load-to-1, wrap flag, and async active-low reset.
- The top level holds the FSM, the shadow register, the output registers and `sync_err`.

## Test plan
- Reset, then `en`=1 with `sync`=1 on the first strobe and `in` = 1,0,1,1,0,0,1,0 for slots 0..7:
  - d0..d7 = 1,0,1,1,0,0,1,0.
  - `frame_valid` is high for one cycle, on the cycle after the 8th strobe.
  - `sync_err` = 0.
- Strobes before any sync:
  - Data is ignored, s2..s0 stay at 0 and there is no `frame_valid`.
- Two back-to-back frames (0xA5 then 0x3C, slot 0 first), with `en` toggling 1,0 each cycle:
  - Each frame's d outputs are correct and `frame_valid` pulses twice.
  - s2..s0 hold during `en`=0 cycles.
- Sync at slot 5 mid-frame:
  - No `frame_valid` pulse, d unchanged and `sync_err`=1 (sticky).
  - The next 8 strobes deliver a correct frame.
- Assert `rst_n` low at slot 4:
  - All outputs go to 0 asynchronously and the FSM returns to IDLE.
  - After release, a new sync frame is delivered correctly.
- With `TDM_DEMUX_PARITY_EN`, frame 0xFF:
  - Parity bit 0: `frame_valid` on the 9th strobe and `parity_err`=0.
  - Parity bit 1: `parity_err` pulses with `frame_valid`.
